// File: rtl/dti_rr_arbiter.sv
// Round-robin arbiter feeding one registered dti output stage from N producers.
// Optional packet lock on the eot bit (data[W-1]) under `ARB_EOT_LOCK_EN.
module dti_rr_arbiter #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N*W-1:0]            din_data,
    input  logic [N-1:0]              din_valid,
    output logic [N-1:0]              din_ready,
    output logic [W-1:0]              dout_data,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic [$clog2(N)-1:0]      dout_sel
);

    localparam int IDXW = $clog2(N);

    logic [IDXW-1:0] r_ptr;
    logic [W-1:0]    r_dout_data;
    logic            r_dout_valid;
    logic [IDXW-1:0] r_dout_sel;

    logic [N-1:0]    w_elig;
    logic            w_any;
    logic            w_load;
    logic            w_release;
    logic [IDXW-1:0] w_g;
    logic [W-1:0]    w_gdata;

    // Scan from the pointer upward, wrapping, and take the first eligible.
    always_comb begin
        int j;
        w_g = '0;
        j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(r_ptr) + k;
            if (j >= N) j = j - N;
            if (w_elig[j]) w_g = IDXW'(j);
        end
    end

    assign w_any   = |w_elig;
    assign w_load  = rst & (~r_dout_valid | dout_ready) & w_any;
    assign w_gdata = din_data[int'(w_g)*W +: W];

    always_comb begin
        din_ready = '0;
        if (w_load) din_ready[w_g] = 1'b1;
    end

`ifdef ARB_EOT_LOCK_EN
    logic            r_lock;
    logic [IDXW-1:0] r_lock_idx;
    logic [N-1:0]    w_lock_mask;

    always_comb begin
        w_lock_mask = '0;
        w_lock_mask[r_lock_idx] = 1'b1;
    end

    assign w_elig    = r_lock ? (din_valid & w_lock_mask) : din_valid;
    assign w_release = w_load & w_gdata[W-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_load) begin
            r_lock     <= ~w_gdata[W-1];
            r_lock_idx <= w_g;
        end
    end
`else
    assign w_elig    = din_valid;
    assign w_release = w_load;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_release) begin
            r_ptr <= (w_g == IDXW'(N - 1)) ? '0 : w_g + 1'b1;
        end
    end

    // A new beat may replace the draining one in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout_valid <= 1'b0;
            r_dout_data  <= '0;
            r_dout_sel   <= '0;
        end else if (w_load) begin
            r_dout_valid <= 1'b1;
            r_dout_data  <= w_gdata;
            r_dout_sel   <= w_g;
        end else if (r_dout_valid & dout_ready) begin
            r_dout_valid <= 1'b0;
        end
    end

    assign dout_data  = r_dout_data;
    assign dout_valid = r_dout_valid;
    assign dout_sel   = r_dout_sel;

endmodule
